serial_deshifter16: RTL and testbench
=====================================

Name: serial_deshifter16

Overview:
- Serial-to-parallel receive end for the shifter16 parallel-load shift register.
- shifter16 shifts a loaded word out one bit per cycle; this block takes that bit stream back in and rebuilds the 16-bit word.
- It presents the word on a valid/ready output register.
- It flags words lost when the downstream consumer stalls.

Parameters:
WIDTH, 16, word length in bits; the bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous reset, active-high (asserted when 1); codebase port name kept
sin  input  1  serial data bit
sin_valid  input  1  sin is valid this cycle
sof  input  1  start of frame; qualified by sin_valid; marks bit 0 of a word
dir  input  1  0 = MSB-first (left-shift transmitter), 1 = LSB-first (right-shift transmitter); sampled only on an accepted sof
clr_err  input  1  synchronous clear of overrun
data_out  output  WIDTH  assembled word
out_valid  output  1  data_out holds an unconsumed word
out_ready  input  1  consumer accepts data_out when out_valid=1
busy  output  1  state != IDLE
overrun  output  1  sticky: a word or bit was dropped

Behaviour:
- Reset (reset_n=1, asynchronous, including mid-frame):
  - outputs: data_out=0, out_valid=0, overrun=0, busy=0.
  - internal: state=IDLE, shift register=0, bit count=0, latched dir=0.
  - any partial frame is discarded.
- Bit accept: a cycle with sin_valid=1. Cycles with sin_valid=0 change nothing; gaps between bits are allowed.
- Shift rule:
  - dir_l=0: sr <= {sr[WIDTH-2:0], sin}.
  - dir_l=1: sr <= {sin, sr[WIDTH-1:1]}.
- Output slot free = (out_valid==0) or (out_ready==1) in the same cycle.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - sin_valid & sof: latch dir into dir_l, shift in the first bit, count=1, go to SHIFT.
  - sin_valid without sof: ignored.
- SHIFT:
  - Each accepted bit shifts in and increments count.
  - sin_valid & sof: abort the current frame and restart. This bit becomes bit 0, count=1, dir relatched. No flag is raised.
  - Accepted bit with count==WIDTH-1 (the last bit):
    - slot free: data_out <= assembled word (including this bit), out_valid=1 from the next cycle, go to IDLE.
    - slot not free: keep the assembled word internally, go to HOLD.
- HOLD:
  - when slot free: transfer the held word to data_out, out_valid=1, go to IDLE.
  - any sin_valid while in HOLD (sof or not, including the cycle the word transfers): bit is dropped, overrun <= 1.
- Latency: last bit accepted at edge k -> data_out and out_valid updated at edge k, visible in cycle k+1.
- Output handshake:
  - out_valid & out_ready at an edge consumes the word; out_valid -> 0 unless a new word loads at the same edge.
  - On a same-edge load, out_valid stays 1 with the new data.
  - data_out is stable while out_valid=1 and out_ready=0.
  - data_out keeps its last value after consumption.
- overrun:
  - sticky; cleared by clr_err=1 at an edge.
  - a same-edge set takes priority over clr_err.
- Count wrap: count returns to 0 on frame completion or abort. It never exceeds WIDTH-1.

Test Plan:
1. dir=0, out_ready=1: send 0xA5C3 MSB-first, 16 consecutive valid bits, sof on the first -> data_out=0xA5C3, out_valid=1 for exactly 1 cycle, starting 1 cycle after the last bit; busy=0 afterwards.
2. dir=1: send 0x1234 LSB-first (bit order 0,0,1,0,1,1,0,0,...) with sin_valid deasserted every other cycle -> data_out=0x1234.
3. out_ready=0: send 0x00FF then 0xFF00 back-to-back -> after the second frame busy=1 (HOLD). One more valid bit -> overrun=1. Raise out_ready -> 0x00FF consumed, 0xFF00 valid next cycle. clr_err -> overrun=0.
4. Send 7 bits of a frame, then a new sof followed by 0xBEEF MSB-first -> a single word 0xBEEF, overrun=0.
5. Assert reset_n=1 asynchronously after 9 bits -> all outputs 0 immediately. After release, frame 0x8001 -> data_out=0x8001.
6. out_valid=1 with out_ready=1 on the same edge as the last bit of 0x5A5A -> out_valid stays 1, data_out=0x5A5A, no overrun.

Source files
------------

// File: rtl/serial_deshifter16.sv
// serial_deshifter16: rebuilds a WIDTH-bit word from a serial bit stream
// (MSB- or LSB-first, chosen per frame) and presents it on a valid/ready
// output register. Bits that arrive while a finished word waits for the
// output slot are dropped and flagged in a sticky overrun bit.
module serial_deshifter16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,   // active-high asynchronous reset
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    input  logic             dir,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, sr_base, sr_shift, load_word;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dir_l, dir_nxt, dir_eff;
    logic             slot_free, start, load, ovr_set;

    // Shared datapath: a start-of-frame shifts into a cleared register with the
    // freshly sampled direction so leftovers of an aborted frame never leak.
    always_comb begin
        slot_free = !out_valid || out_ready;
        start     = sin_valid && sof && (state != HOLD);
        dir_eff   = start ? dir : dir_l;
        sr_base   = start ? '0 : sr;
        sr_shift  = dir_eff ? {sin, sr_base[WIDTH-1:1]} : {sr_base[WIDTH-2:0], sin};
        // In HOLD the finished word sits in sr; otherwise it includes this bit.
        load_word = (state == HOLD) ? sr : sr_shift;
    end

    // Next-state logic: frame start/abort, bit accumulation, completion and hold.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        dir_nxt   = dir_l;
        load      = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (start) begin
                    dir_nxt   = dir;
                    sr_nxt    = sr_shift;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end else if (sin_valid && state == SHIFT) begin
                    sr_nxt = sr_shift;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt_nxt = '0;
                        if (slot_free) begin
                            load      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                // No room for bits here, even on the cycle the word leaves.
                ovr_set = sin_valid;
                if (slot_free) begin
                    load      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Shift register, bit counter and latched direction.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sr    <= '0;
            cnt   <= '0;
            dir_l <= 1'b0;
        end else begin
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
            dir_l <= dir_nxt;
        end
    end

    // Output register: a load at the same edge as a consume keeps out_valid high.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            data_out  <= load_word;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop wins over a same-edge clear.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n)      overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (clr_err) overrun <= 1'b0;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_deshifter16.sv
// Bench for serial_deshifter16: words are queued as they are sent and
// compared whenever the DUT hands one over (out_valid & out_ready).
module tb_serial_deshifter16;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sin = 1'b0, sin_valid = 1'b0, sof = 1'b0, dir = 1'b0, clr_err = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] data_out;
    logic        out_valid, busy, overrun;

    logic [15:0] exp_q[$];
    int          n_chk = 0, n_pass = 0;

    serial_deshifter16 #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .dir(dir), .clr_err(clr_err), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s, input logic d);
        sin = b; sof = s; dir = d; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0; sof = 1'b0;
    endtask

    // Send a whole word; gap inserts an idle cycle after each bit,
    // rdy_last raises out_ready just before the final bit.
    task automatic send_word(input logic [15:0] w, input logic d, input logic gap,
                             input logic rdy_last);
        exp_q.push_back(w);
        for (int i = 0; i < 16; i++) begin
            if (i == 15 && rdy_last) out_ready = 1'b1;
            send_bit(d ? w[i] : w[15-i], i == 0, d);
            if (gap && i != 15) tick();
        end
    endtask

    // Scoreboard: every handed-over word must be the oldest one sent.
    always @(negedge clk) begin
        if (!reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", {16'h0, data_out}, 32'hFFFF_FFFF);
            else                   chk("word", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
        end
    end

    initial begin
        // reset state
        #2;
        chk("rst_data", {16'h0, data_out}, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        tick(); tick();
        reset_n = 1'b0;
        tick();

        // 1: MSB-first, back-to-back bits
        send_word(16'hA5C3, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", {16'h0, data_out}, 32'hA5C3);
        chk("t1_busy_on_load", busy, 0);
        tick();
        chk("t1_valid_1cyc", out_valid, 0);
        chk("t1_busy", busy, 0);

        // 2: LSB-first with gaps
        send_word(16'h1234, 1'b1, 1'b1, 1'b0);
        chk("t2_data", {16'h0, data_out}, 32'h1234);
        tick();

        // 3: stall, hold, overrun, release, clear
        out_ready = 1'b0;
        send_word(16'h00FF, 1'b0, 1'b0, 1'b0);
        send_word(16'hFF00, 1'b0, 1'b0, 1'b0);
        chk("t3_busy_hold", busy, 1);
        chk("t3_stable", {16'h0, data_out}, 32'h00FF);
        chk("t3_ovr_pre", overrun, 0);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("t3_ovr", overrun, 1);
        out_ready = 1'b1;
        tick();
        chk("t3_next_valid", out_valid, 1);
        chk("t3_next_data", {16'h0, data_out}, 32'hFF00);
        chk("t3_idle", busy, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr", overrun, 0);

        // 4: abort after 7 bits, restart with 0xBEEF
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(1)), i == 0, 1'b0);
        chk("t4_busy_partial", busy, 1);
        send_word(16'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("t4_data", {16'h0, data_out}, 32'hBEEF);
        chk("t4_ovr", overrun, 0);
        tick();
        chk("t4_single", out_valid, 0);

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0, 1'b0);
        #2 reset_n = 1'b1;
        #1;
        chk("t5_data", {16'h0, data_out}, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovr", overrun, 0);
        #2 reset_n = 1'b0;
        tick();
        send_word(16'h8001, 1'b0, 1'b0, 1'b0);
        chk("t5_after", {16'h0, data_out}, 32'h8001);
        tick();

        // 6: consume and load on the same edge
        out_ready = 1'b0;
        send_word(16'h1111, 1'b1, 1'b0, 1'b0);
        send_word(16'h5A5A, 1'b0, 1'b0, 1'b1);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", {16'h0, data_out}, 32'h5A5A);
        chk("t6_ovr", overrun, 0);
        chk("t6_busy", busy, 0);
        tick(); tick();
        chk("t6_drained", out_valid, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
